// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree walker: node-word layout, FSM states, node type.
package dtree_pkg;

  localparam int NODE_W    = 29;
  localparam int CLASS_W   = 5;
  localparam int LEAF_BIT  = 28;
  localparam int FIDX_LSB  = 25;
  localparam int THR_LSB   = 17;
  localparam int LEFT_LSB  = 11;
  localparam int RIGHT_LSB = 5;
  localparam int CLASS_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic               leaf;
    logic [2:0]         fidx;
    logic [7:0]         thr;
    logic [5:0]         left;
    logic [5:0]         right;
    logic [CLASS_W-1:0] cls;
  } node_t;

  function automatic node_t decode_node(input logic [NODE_W-1:0] w);
    node_t d;
    d.leaf  = w[LEAF_BIT];
    d.fidx  = w[FIDX_LSB +: 3];
    d.thr   = w[THR_LSB +: 8];
    d.left  = w[LEFT_LSB +: 6];
    d.right = w[RIGHT_LSB +: 6];
    d.cls   = w[CLASS_LSB +: CLASS_W];
    return d;
  endfunction

endpackage

// File: rtl/dtree_node_mem.sv
// Node table: one synchronous write port, one combinational read port, cleared on reset.
module dtree_node_mem
  import dtree_pkg::*;
#(
  parameter int NNODES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [5:0]        i_waddr,
  input  logic [NODE_W-1:0] i_wdata,
  input  logic [5:0]        i_raddr,
  output logic [NODE_W-1:0] o_rdata
);

  logic [NODE_W-1:0] r_mem [NNODES];
  logic              w_rd_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Child pointers beyond the table read as an all-zero node.
  assign w_rd_ok = ({26'd0, i_raddr} < 32'(NNODES));
  assign o_rdata = w_rd_ok ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/dtree_seq_ctrl.sv
// Sequential decision-tree walker: one node per cycle from a configurable node table.
// Optional DTREE_PERF_EN adds out_depth and a saturating perf_cnt of completed results.
module dtree_seq_ctrl
  import dtree_pkg::*;
#(
  parameter int NFEAT     = 7,
  parameter int NNODES    = 64,
  parameter int MAX_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*NFEAT-1:0] in_feat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         out_class,
  output logic               out_err,
  input  logic               cfg_we,
  input  logic [5:0]         cfg_addr,
  input  logic [28:0]        cfg_data,
  output logic               cfg_err
`ifdef DTREE_PERF_EN
  ,
  output logic [4:0]         out_depth,
  output logic [15:0]        perf_cnt
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // out_valid/out_class/out_err hold steady until that transfer completes.

  localparam logic [4:0] LAST_DEPTH = 5'(MAX_DEPTH - 1);

  state_e               r_state;
  logic [8*NFEAT-1:0]   r_feat;
  logic [5:0]           r_ptr;
  logic [4:0]           r_depth;
  logic [CLASS_W-1:0]   r_out_class;
  logic                 r_out_err;
  logic                 r_cfg_err;

  logic [NODE_W-1:0]    w_node_word;
  node_t                w_node;
  logic [7:0]           w_fval;
  logic                 w_addr_ok;
  logic                 w_cfg_wr;
  logic                 w_accept;

  assign w_addr_ok = ({26'd0, cfg_addr} < 32'(NNODES));
  assign w_cfg_wr  = cfg_we && (r_state == ST_IDLE) && w_addr_ok;
  assign in_ready  = (r_state == ST_IDLE) && !cfg_we;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign out_class = r_out_class;
  assign out_err   = r_out_err;
  assign cfg_err   = r_cfg_err;

  dtree_node_mem #(.NNODES(NNODES)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_cfg_wr),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (r_ptr),
    .o_rdata (w_node_word)
  );

  assign w_node = decode_node(w_node_word);

  // Indices past the last feature fall through the loop and read as zero.
  always_comb begin
    w_fval = 8'd0;
    for (int i = 0; i < NFEAT; i++) begin
      if ({29'd0, w_node.fidx} == 32'(i)) w_fval = r_feat[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_feat      <= '0;
      r_ptr       <= '0;
      r_depth     <= '0;
      r_out_class <= '0;
      r_out_err   <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_wr;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_feat  <= in_feat;
            r_ptr   <= '0;
            r_depth <= '0;
            r_state <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (w_node.leaf) begin
            r_out_class <= w_node.cls;
            r_out_err   <= 1'b0;
            r_state     <= ST_DONE;
          end else if (r_depth == LAST_DEPTH) begin
            r_out_class <= '0;
            r_out_err   <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_ptr   <= (w_fval <= w_node.thr) ? w_node.left : w_node.right;
            r_depth <= r_depth + 5'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DTREE_PERF_EN
  logic [4:0]  r_out_depth;
  logic [15:0] r_perf_cnt;

  // Leaf and depth-limit exits both finish at the current depth, so one capture covers both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_depth <= '0;
      r_perf_cnt  <= '0;
    end else begin
      if (r_state == ST_WALK && (w_node.leaf || r_depth == LAST_DEPTH)) r_out_depth <= r_depth;
      if (out_valid && out_ready && r_perf_cnt != 16'hFFFF) r_perf_cnt <= r_perf_cnt + 16'd1;
    end
  end

  assign out_depth = r_out_depth;
  assign perf_cnt  = r_perf_cnt;
`endif

endmodule

// File: doc/dtree_seq_ctrl.md
DTREE_SEQ_CTRL -- requirements
Module: dtree_seq_ctrl

Interface
REQ-001 SHALL have parameter NFEAT, default 7, number of 8-bit input features.
REQ-002 SHALL have parameter NNODES, default 64, node-table depth.
REQ-003 SHALL have parameter MAX_DEPTH, default 16, maximum number of nodes visited per walk.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, feature vector valid.
REQ-007 SHALL have port in_ready, output, 1, controller accepts a feature vector.
REQ-008 SHALL have port in_feat, input, 8*NFEAT, packed features; feature i is at bits [8i+7:8i].
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port out_class, output, 5, class label.
REQ-012 SHALL have port out_err, output, 1, depth limit hit with no leaf reached.
REQ-013 SHALL have port cfg_we, input, 1, node-table write strobe.
REQ-014 SHALL have port cfg_addr, input, 6, node index.
REQ-015 SHALL have port cfg_data, input, 29, node word.
REQ-016 SHALL have port cfg_err, output, 1, one-cycle pulse when a write is rejected.

Function
REQ-017 SHALL decode the node word as follows: [28] leaf, [27:25] feature index, [24:17] threshold, [16:11] left child, [10:5] right child, [4:0] class.
REQ-018 SHALL implement FSM states IDLE, WALK and DONE.
REQ-019 SHALL assert in_ready in IDLE only, and only when cfg_we=0.
REQ-020 SHALL, on in_valid&&in_ready, latch in_feat, set ptr=0 and depth=0, and go to WALK.
REQ-021 SHALL, in WALK, evaluate node[ptr] once per cycle using a combinational table read.
REQ-022 SHALL, on a leaf node, register class into out_class, clear out_err, and go to DONE.
REQ-023 SHALL, on a non-leaf node, select left if feature[idx] <= threshold (unsigned 8-bit compare) and right otherwise, then increment depth.
REQ-024 SHALL, when a non-leaf node is evaluated with depth==MAX_DEPTH-1, set out_class=0 and out_err=1 and go to DONE.
REQ-025 SHALL treat a feature index >= NFEAT as a read of value 0.
REQ-026 SHALL timestamp the input handshake as cycle 0; the node at depth k is evaluated in cycle k+1, and for a leaf at depth d, out_valid is high from cycle d+2.
REQ-027 SHALL, in DONE, hold out_valid=1 with out_class and out_err stable until out_ready=1, then return to IDLE.
REQ-028 SHALL NOT accept a new vector in the cycle that DONE completes; the next handshake is possible no earlier than the following cycle.
REQ-029 SHALL perform a cfg_we write in IDLE at the next clock edge; cfg_we has priority over in_valid in the same cycle.
REQ-030 SHALL ignore cfg_we in WALK or DONE, leave the table unchanged, and pulse cfg_err for one cycle.
REQ-031 SHALL ignore writes with cfg_addr >= NNODES and pulse cfg_err.

Reset
REQ-032 SHALL, on rst, go to IDLE with out_valid=0, out_class=0, out_err=0, cfg_err=0, ptr=0, depth=0, and all node-table entries cleared to 0.
REQ-033 SHALL let rst asserted during WALK or DONE abort the walk with no output produced.
REQ-034 SHALL, with a cleared table, loop on the root node; a walk then ends in err.

Configuration
REQ-035 SHALL, when DTREE_PERF_EN is defined, add output out_depth[4:0], equal to the leaf depth and captured with out_class; on err it is MAX_DEPTH-1.
REQ-036 SHALL, when DTREE_PERF_EN is defined, add output perf_cnt[15:0], a saturating count of completed out handshakes, cleared by rst.
REQ-037 SHALL, without DTREE_PERF_EN, omit both ports and their logic; all other behaviour is identical.

Structure
REQ-038 SHALL place the following in package dtree_pkg: the node-word field offsets, the state enum, the node_t typedef and the class-width constant.
REQ-039 SHALL contain one sub-module, dtree_node_mem: the node table with a write port and a combinational read port.

Verification
REQ-040 SHALL cover this scenario: root=leaf class 7 with features arbitrary -> out_valid in cycle 2, out_class=7, out_err=0.
REQ-041 SHALL cover this scenario: root {f0, thr 0x80, L=1, R=2}, node1 leaf 3, node2 leaf 9; f0=0x80 -> class 3; f0=0x81 -> class 9, valid in cycle 3.
REQ-042 SHALL cover this scenario: table after reset and any vector -> out_valid in cycle 17, out_err=1, out_class=0.
REQ-043 SHALL cover this scenario: out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0 throughout; release -> IDLE the next cycle.
REQ-044 SHALL cover this scenario: cfg_we during WALK at addr 1 -> cfg_err one-cycle pulse, and a re-run yields the old result; cfg_we and in_valid together in IDLE -> write done, vector not accepted.
REQ-045 SHALL cover this scenario: rst mid-WALK -> out_valid never rises, the table is cleared, and in_ready=1 the cycle after rst deasserts.
